// File: rtl/face_box_sched.sv
// face_box_sched: collects one box per detector half after each frame
// and publishes validated boxes to the overlay with per-slot hold-off.
module face_box_sched #(
  parameter int COL         = 1280,
  parameter int ROW         = 720,
  parameter int TIMEOUT     = 64,
  parameter int HOLD_FRAMES = 3
) (
  input  logic         video_pclk,
  input  logic         rst,
  input  logic         frame_end,
  input  logic [1:0]   req,
  input  logic [1:0]   req_hit,
  input  logic [127:0] req_box,
  output logic [1:0]   ack,
  output logic [1:0]   box_valid,
  output logic [127:0] box,
  output logic         busy,
  output logic [7:0]   overrun_cnt
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] COL_U = 32'(COL);
  localparam logic [31:0] ROW_U = 32'(ROW);
  localparam logic [7:0] HOLD_U = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [1:0]        got_q, got_d;
  logic [1:0]        stg_hit_q, stg_hit_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        vld_q, vld_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [1:0][63:0]  stg_q, stg_d;
  logic [1:0][63:0]  box_q, box_d;
  logic [1:0][7:0]   miss_q, miss_d;
  logic [7:0]        ovr_q, ovr_d;
  logic [1:0][63:0]  rbox;
  logic [1:0]        elig;
  logic              gi;

  assign rbox = req_box;
  assign elig = req & ~got_q;
  // With both eligible rr picks; otherwise the lone eligible one wins.
  assign gi = (elig == 2'b11) ? rr_q : elig[1];

  // {up, down, left, right}
  function automatic logic geom_ok(input logic [63:0] b);
    return (b[63:48] <= b[47:32]) &&
           (b[31:16] <= b[15:0]) &&
           (32'(b[47:32]) < ROW_U) &&
           (32'(b[15:0]) < COL_U);
  endfunction

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    got_d     = got_q;
    stg_hit_d = stg_hit_q;
    ack_d     = '0;
    vld_d     = vld_q;
    tcnt_d    = tcnt_q;
    stg_d     = stg_q;
    box_d     = box_q;
    miss_d    = miss_q;
    ovr_d     = ovr_q;
    if (frame_end && state_q != IDLE && ovr_q != 8'hff)
      ovr_d = ovr_q + 8'd1;
    unique case (state_q)
      IDLE: begin
        if (frame_end) begin
          state_d   = COLLECT;
          got_d     = '0;
          tcnt_d    = '0;
          stg_hit_d = '0;
        end
      end
      COLLECT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (elig != 2'b00) begin
          ack_d[gi]     = 1'b1;
          stg_d[gi]     = rbox[gi];
          stg_hit_d[gi] = req_hit[gi];
          got_d[gi]     = 1'b1;
          rr_d          = ~gi;
        end
        if (got_q == 2'b11 || tcnt_q == TLAST)
          state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < 2; i++) begin
          if (got_q[i] && stg_hit_q[i] && geom_ok(stg_q[i])) begin
            box_d[i]  = stg_q[i];
            vld_d[i]  = 1'b1;
            miss_d[i] = 8'd0;
          end else if (miss_q[i] >= HOLD_U) begin
            vld_d[i] = 1'b0;
          end else if (miss_q[i] != 8'hff) begin
            miss_d[i] = miss_q[i] + 8'd1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge video_pclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      got_q     <= '0;
      stg_hit_q <= '0;
      ack_q     <= '0;
      vld_q     <= '0;
      tcnt_q    <= '0;
      stg_q     <= '0;
      box_q     <= '0;
      miss_q    <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      got_q     <= got_d;
      stg_hit_q <= stg_hit_d;
      ack_q     <= ack_d;
      vld_q     <= vld_d;
      tcnt_q    <= tcnt_d;
      stg_q     <= stg_d;
      box_q     <= box_d;
      miss_q    <= miss_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ack         = ack_q;
  assign box_valid   = vld_q;
  assign box         = box_q;
  assign busy        = (state_q != IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_face_box_sched.sv
// Scoreboard bench for face_box_sched: random frames checked against
// a frame-level model of grants, commits and hold-off.
module tb_face_box_sched;
  localparam int COL     = 1280;
  localparam int ROW     = 720;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 3;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         frame_end = 1'b0;
  logic [1:0]   req       = '0;
  logic [1:0]   req_hit   = '0;
  logic [127:0] req_box   = '0;
  logic [1:0]   ack;
  logic [1:0]   box_valid;
  logic [127:0] box;
  logic         busy;
  logic [7:0]   overrun_cnt;

  face_box_sched #(
    .COL(COL), .ROW(ROW), .TIMEOUT(TIMEOUT), .HOLD_FRAMES(HOLD)
  ) dut (
    .video_pclk (clk),
    .rst        (rst),
    .frame_end  (frame_end),
    .req        (req),
    .req_hit    (req_hit),
    .req_box    (req_box),
    .ack        (ack),
    .box_valid  (box_valid),
    .box        (box),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    int         off;
  } ack_exp_t;

  typedef struct {
    logic [1:0]   v;
    logic [127:0] b;
    int           off;
  } cmt_exp_t;

  ack_exp_t aq[$];
  cmt_exp_t cq[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int fe_cyc = 0;
  bit busy_prev = 1'b0;

  bit          m_rr;
  bit [1:0]    m_v;
  logic [63:0] m_b [2];
  int          m_miss [2];
  int          m_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mkbox(input int u, input int d,
                                        input int l, input int r);
    return {16'(u), 16'(d), 16'(l), 16'(r)};
  endfunction

  function automatic bit box_ok(input logic [63:0] b);
    int up, dn, lf, rt;
    up = int'(b[63:48]);
    dn = int'(b[47:32]);
    lf = int'(b[31:16]);
    rt = int'(b[15:0]);
    return up <= dn && lf <= rt && dn < ROW && rt < COL;
  endfunction

  function automatic logic [63:0] rand_box();
    int u, d, l, r, t;
    u = $urandom_range(0, ROW - 1);
    d = $urandom_range(u, ROW - 1);
    l = $urandom_range(0, COL - 1);
    r = $urandom_range(l, COL - 1);
    case ($urandom_range(0, 9))
      0: d = ROW;
      1: r = COL;
      2: if (u != d) begin t = u; u = d; d = t; end
      3: if (l != r) begin t = l; l = r; r = t; end
      default: ;
    endcase
    return mkbox(u, d, l, r);
  endfunction

  task automatic model_reset();
    m_rr = 1'b0;
    m_v = '0;
    m_ovr = 0;
    for (int i = 0; i < 2; i++) begin
      m_b[i] = '0;
      m_miss[i] = 0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows an ack or a commit.
  always @(negedge clk) begin : mon
    ack_exp_t ea;
    cmt_exp_t ec;
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (ack != 2'b00) begin
        checks++;
        if (aq.size() == 0) begin
          errs++;
          $display("FAIL ack_unexpected: got %b at +%0d", ack, cyc - fe_cyc);
        end else begin
          ea = aq.pop_front();
          if (ack !== ea.a || cyc - fe_cyc != ea.off) begin
            errs++;
            $display("FAIL ack: got %b at +%0d expected %b at +%0d",
                     ack, cyc - fe_cyc, ea.a, ea.off);
          end
        end
      end
      if (busy_prev && !busy) begin
        checks++;
        if (cq.size() == 0) begin
          errs++;
          $display("FAIL commit_unexpected: at +%0d", cyc - fe_cyc);
        end else begin
          ec = cq.pop_front();
          if (box_valid !== ec.v || box !== ec.b ||
              cyc - fe_cyc != ec.off) begin
            errs++;
            $display("FAIL commit: got v=%b box=%h at +%0d expected v=%b box=%h at +%0d",
                     box_valid, box, cyc - fe_cyc, ec.v, ec.b, ec.off);
          end
        end
      end
      busy_prev = busy;
    end
  end

  task automatic do_frame(input logic [1:0] pres, input logic [1:0] hit,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input bit ovr);
    int n;
    bit first, second;
    logic [1:0] ackl;
    logic [63:0] bx [2];
    bx[0] = b0;
    bx[1] = b1;
    @(posedge clk); #1;
    fe_cyc = cyc;
    if (pres == 2'b11) begin
      first = m_rr;
      second = ~first;
      aq.push_back('{a: first ? 2'b10 : 2'b01, off: 2});
      aq.push_back('{a: second ? 2'b10 : 2'b01, off: 3});
      m_rr = ~second;
    end else if (pres != 2'b00) begin
      aq.push_back('{a: pres, off: 2});
      m_rr = ~pres[1];
    end
    for (int i = 0; i < 2; i++) begin
      if (pres[i] && hit[i] && box_ok(bx[i])) begin
        m_b[i] = bx[i];
        m_v[i] = 1'b1;
        m_miss[i] = 0;
      end else if (m_miss[i] >= HOLD) begin
        m_v[i] = 1'b0;
      end else begin
        m_miss[i] = (m_miss[i] == 255) ? 255 : m_miss[i] + 1;
      end
    end
    cq.push_back('{v: m_v, b: {m_b[1], m_b[0]},
                   off: (pres == 2'b11) ? 5 : TIMEOUT + 2});
    if (ovr) m_ovr = (m_ovr == 255) ? 255 : m_ovr + 1;

    req_box = {b1, b0};
    req_hit = hit;
    req = pres;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    n = 1;
    ackl = '0;
    while (busy && n < TIMEOUT + 8) begin
      frame_end = ovr && (n == 2);
      @(posedge clk); #1;
      n++;
      req = req & ~ackl;
      ackl = ack;
    end
    checks++;
    if (busy) begin
      errs++;
      $display("FAIL frame_timeout: busy=%b after %0d cycles expected 0",
               busy, n);
    end
    frame_end = 1'b0;
    req = '0;
    @(negedge clk); #1;
    chk("ack_drained", 128'(aq.size()), 128'd0);
    chk("commit_drained", 128'(cq.size()), 128'd0);
    chk("overrun_cnt", 128'(overrun_cnt), 128'(m_ovr));
    aq.delete();
    cq.delete();
  endtask

  task automatic reset_mid_collect();
    @(posedge clk); #1;
    fe_cyc = cyc;
    req_box = {mkbox(1, 2, 3, 4), mkbox(5, 6, 7, 8)};
    req_hit = 2'b11;
    req = 2'b11;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_box_valid", 128'(box_valid), 128'd0);
    chk("rst_box", box, 128'd0);
    chk("rst_overrun", 128'(overrun_cnt), 128'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ack", 128'(ack), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    model_reset();
    aq.delete();
    cq.delete();
    @(negedge clk);
    chk("post_rst_ack", 128'(ack), 128'd0);
    chk("post_rst_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    logic [63:0] b0, b1;
    logic [1:0] pres, hit;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", 128'(ack), 128'd0);
    chk("reset_box_valid", 128'(box_valid), 128'd0);
    chk("reset_box", box, 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_overrun", 128'(overrun_cnt), 128'd0);

    b0 = mkbox(100, 200, 50, 300);
    b1 = mkbox(120, 220, 700, 900);
    do_frame(2'b11, 2'b11, b0, b1, 1'b0);
    repeat (3) do_frame(2'b11, 2'b11, b0, b1, 1'b0);
    do_frame(2'b01, 2'b11, b0, b1, 1'b0);
    do_frame(2'b11, 2'b11, b1, b0, 1'b0);

    do_frame(2'b11, 2'b11, mkbox(10, 20, 30, 40), b1, 1'b0);
    repeat (4) do_frame(2'b11, 2'b00, b0, b1, 1'b0);

    do_frame(2'b11, 2'b11, b0, b1, 1'b0);
    do_frame(2'b11, 2'b11, mkbox(300, 200, 50, 300), b1, 1'b0);
    do_frame(2'b11, 2'b11, mkbox(100, 200, 50, COL), b1, 1'b0);
    do_frame(2'b11, 2'b11, mkbox(100, ROW, 50, 300), b1, 1'b0);
    do_frame(2'b11, 2'b11, mkbox(0, ROW - 1, 0, COL - 1), b1, 1'b0);

    do_frame(2'b11, 2'b11, b0, b1, 1'b1);

    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 9);
      pres = (r < 7) ? 2'b11 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b00;
      hit = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      do_frame(pres, hit, rand_box(), rand_box(),
               $urandom_range(0, 4) == 0);
    end

    reset_mid_collect();
    do_frame(2'b11, 2'b11, b0, b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
